// File: rtl/eth_rx_fifo_pkg.sv
// Shared types and widths for the ethernet RX store-and-forward frame buffer.
package eth_rx_fifo_pkg;
  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;
  localparam int ENTRY_W = 1 + KEEP_W + DATA_W;

  // Write-side frame state: storing a frame, or discarding the rest of one.
  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  // One buffer entry as stored in the RAM.
  typedef struct packed {
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
  } entry_t;
endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-Stream bundle used on both sides of the RX frame buffer.
interface eth_rx_frame_fifo_if;
  import eth_rx_fifo_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_rx_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module eth_rx_fifo_ram
  import eth_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);
  logic [ENTRY_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [ENTRY_W-1:0] r_rdata;

  // Write port; the array has no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port with one cycle of latency.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: frames become visible downstream only once
// their tlast beat arrives without error; errored and overflowing frames are
// dropped whole and counted. The MAC side is never stalled.
module eth_rx_frame_fifo
  import eth_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  async_resetn,
  eth_rx_frame_fifo_if.slave    s_axis,
  eth_rx_frame_fifo_if.master   m_axis,
  output logic [CNT_W-1:0]      cnt_frames_ok,
  output logic [CNT_W-1:0]      cnt_frames_err,
  output logic [CNT_W-1:0]      cnt_frames_ovf,
  output logic [DEPTH_LOG2:0]   fifo_level
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << DEPTH_LOG2;

  wr_state_t        r_state;
  logic [PW-1:0]    r_wr_ptr, r_commit_ptr, r_rd_ptr, r_fetch_ptr, r_level;
  logic             r_tready, r_rd_pend;
  logic [1:0]       r_cnt;
  entry_t           r_s0, r_s1;
  logic [CNT_W-1:0] r_ok, r_err, r_ovf;

  logic             w_beat, w_full, w_wr_en, w_rd_en, w_valid, w_pop;
  logic [1:0]       w_cnt_next;
  entry_t           w_s0_next, w_s1_next, w_wr_entry, w_rd_data;
  logic [ENTRY_W-1:0] w_rd_raw;

  // rd_ptr advances only when a beat leaves the output stage, so space held
  // in the skid buffer is still counted as occupied; r_fetch_ptr runs ahead
  // of it and addresses the RAM.
  assign w_beat     = s_axis.tvalid & r_tready;
  assign w_full     = (r_wr_ptr - r_rd_ptr) == DEPTH;
  assign w_wr_en    = w_beat & (r_state == ACCEPT) & ~w_full;
  assign w_wr_entry = '{tlast: s_axis.tlast, tkeep: s_axis.tkeep, tdata: s_axis.tdata};
  assign w_valid    = (r_cnt != 2'd0);
  assign w_pop      = w_valid & m_axis.tready;
  assign w_rd_data  = entry_t'(w_rd_raw);

  eth_rx_fifo_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk     (clock),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (w_wr_entry),
    .i_re    (w_rd_en),
    .i_raddr (r_fetch_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd_raw)
  );

  // Skid buffer next state: pop the head, then append the RAM beat landing now.
  always_comb begin
    w_s0_next  = r_s0;
    w_s1_next  = r_s1;
    w_cnt_next = r_cnt;
    if (w_pop) begin
      w_s0_next  = r_s1;
      w_cnt_next = r_cnt - 2'd1;
    end
    if (r_rd_pend) begin
      if (w_cnt_next == 2'd0) w_s0_next = w_rd_data;
      else                    w_s1_next = w_rd_data;
      w_cnt_next = w_cnt_next + 2'd1;
    end
  end

  // A new read is issued only if its data is guaranteed a free skid slot.
  assign w_rd_en = (r_fetch_ptr != r_commit_ptr) & (w_cnt_next < 2'd2);

  // Write FSM: store, commit or roll back frames, and count outcomes.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_state      <= ACCEPT;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_ok         <= '0;
      r_err        <= '0;
      r_ovf        <= '0;
    end else if (w_beat) begin
      case (r_state)
        ACCEPT: begin
          if (!w_full) begin
            if (s_axis.tlast && !s_axis.tuser) begin
              r_wr_ptr     <= r_wr_ptr + PW'(1);
              r_commit_ptr <= r_wr_ptr + PW'(1);
              r_ok         <= r_ok + CNT_W'(1);
            end else if (s_axis.tlast) begin
              r_wr_ptr <= r_commit_ptr;
              r_err    <= r_err + CNT_W'(1);
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
            end
          end else begin
            r_wr_ptr <= r_commit_ptr;
            if (s_axis.tlast) r_ovf   <= r_ovf + CNT_W'(1);
            else              r_state <= DROP;
          end
        end
        DROP: begin
          if (s_axis.tlast) begin
            r_ovf   <= r_ovf + CNT_W'(1);
            r_state <= ACCEPT;
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  // Read side: RAM fetch pointer, consumed pointer, skid buffer and level.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_tready    <= 1'b0;
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_rd_pend   <= 1'b0;
      r_cnt       <= 2'd0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_level     <= '0;
    end else begin
      r_tready  <= 1'b1;
      r_rd_pend <= w_rd_en;
      if (w_rd_en) r_fetch_ptr <= r_fetch_ptr + PW'(1);
      if (w_pop)   r_rd_ptr    <= r_rd_ptr + PW'(1);
      r_cnt   <= w_cnt_next;
      r_s0    <= w_s0_next;
      r_s1    <= w_s1_next;
      r_level <= r_commit_ptr - r_rd_ptr;
    end
  end

  assign s_axis.tready  = r_tready;
  assign m_axis.tdata   = r_s0.tdata;
  assign m_axis.tkeep   = r_s0.tkeep;
  assign m_axis.tlast   = r_s0.tlast;
  assign m_axis.tuser   = 1'b0;
  assign m_axis.tvalid  = w_valid;
  assign cnt_frames_ok  = r_ok;
  assign cnt_frames_err = r_err;
  assign cnt_frames_ovf = r_ovf;
  assign fifo_level     = r_level;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed bench for eth_rx_frame_fifo: one instance at full depth and one
// small instance (16 beats) for the overflow and full-buffer cases.
module tb_eth_rx_frame_fifo;
    import eth_rx_fifo_pkg::*;

    logic clock = 1'b0;
    logic async_resetn = 1'b0;
    always #5 clock = ~clock;

    eth_rx_frame_fifo_if s9 ();
    eth_rx_frame_fifo_if m9 ();
    eth_rx_frame_fifo_if s4 ();
    eth_rx_frame_fifo_if m4 ();

    logic [31:0] ok9, err9, ovf9, ok4, err4, ovf4;
    logic [9:0]  lvl9;
    logic [4:0]  lvl4;
    logic        rdy9 = 1'b1, rdy4 = 1'b0, rand_mode = 1'b0, rnd_bit = 1'b0;
    int          checks = 0, errors = 0;
    logic [72:0] rx9[$], rx4[$], exp9[$], exp4[$];

    assign m9.tready = rand_mode ? rnd_bit : rdy9;
    assign m4.tready = rdy4;

    eth_rx_frame_fifo u_dut9 (
        .clock(clock), .async_resetn(async_resetn), .s_axis(s9), .m_axis(m9),
        .cnt_frames_ok(ok9), .cnt_frames_err(err9), .cnt_frames_ovf(ovf9), .fifo_level(lvl9)
    );

    eth_rx_frame_fifo #(.DEPTH_LOG2(4)) u_dut4 (
        .clock(clock), .async_resetn(async_resetn), .s_axis(s4), .m_axis(m4),
        .cnt_frames_ok(ok4), .cnt_frames_err(err4), .cnt_frames_ovf(ovf4), .fifo_level(lvl4)
    );

    always @(posedge clock) rnd_bit <= 1'($urandom_range(0, 1));

    always @(posedge clock) begin
        if (m9.tvalid && m9.tready) rx9.push_back({m9.tlast, m9.tkeep, m9.tdata});
        if (m4.tvalid && m4.tready) rx4.push_back({m4.tlast, m4.tkeep, m4.tdata});
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s value=%0h", tag, obs);
        end
    endtask

    function automatic logic [72:0] mk(input int id, input int b, input bit last, input logic [7:0] lk);
        logic [63:0] d;
        d = {8'hA5, id[7:0], b[15:0], 32'(id * 1000 + b)};
        return {last, (last ? lk : 8'hFF), d};
    endfunction

    task automatic idle();
        s9.tvalid = 1'b0; s9.tlast = 1'b0; s9.tuser = 1'b0; s9.tdata = '0; s9.tkeep = '0;
        s4.tvalid = 1'b0; s4.tlast = 1'b0; s4.tuser = 1'b0; s4.tdata = '0; s4.tkeep = '0;
    endtask

    task automatic send(input bit sel, input int id, input int n, input logic [7:0] lk,
                        input logic user, input bit keep_exp);
        logic [72:0] e;
        for (int b = 0; b < n; b++) begin
            e = mk(id, b, (b == n - 1), lk);
            if (keep_exp) begin
                if (sel) exp4.push_back(e);
                else     exp9.push_back(e);
            end
            if (sel) begin
                s4.tdata = e[63:0]; s4.tkeep = e[71:64]; s4.tlast = e[72];
                s4.tuser = (b == n - 1) ? user : 1'b0; s4.tvalid = 1'b1;
            end else begin
                s9.tdata = e[63:0]; s9.tkeep = e[71:64]; s9.tlast = e[72];
                s9.tuser = (b == n - 1) ? user : 1'b0; s9.tvalid = 1'b1;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic check_stream(input bit sel, input string tag);
        int n;
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (sel ? (rx4.size() >= exp4.size()) : (rx9.size() >= exp9.size())) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!done) begin
            errors++;
            $error("FAIL %s_wait expired before all beats arrived", tag);
        end else begin
            $display("PASS %s_wait", tag);
        end
        repeat (4) @(negedge clock);
        if (sel) begin
            chk($sformatf("%s_count", tag), rx4.size(), exp4.size());
            n = (rx4.size() < exp4.size()) ? rx4.size() : exp4.size();
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_beat%0d", tag, i), rx4[i], exp4[i]);
            end
            rx4.delete(); exp4.delete();
        end else begin
            chk($sformatf("%s_count", tag), rx9.size(), exp9.size());
            n = (rx9.size() < exp9.size()) ? rx9.size() : exp9.size();
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_beat%0d", tag, i), rx9[i], exp9[i]);
            end
            rx9.delete(); exp9.delete();
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int cnt;
        bit seen;
        idle();
        #12;
        chk("rst_s_tready", s9.tready, 1'b0);
        chk("rst_m_tvalid", m9.tvalid, 1'b0);
        chk("rst_ok", ok9, 32'd0);
        chk("rst_level", lvl9, 10'd0);
        chk("rst_m_tvalid4", m4.tvalid, 1'b0);
        @(negedge clock);
        async_resetn = 1'b1;
        @(posedge clock); #1;
        chk("s_tready", s9.tready, 1'b1);
        chk("s_tready4", s4.tready, 1'b1);

        send(0, 1, 8, 8'h0F, 1'b0, 1'b1);
        idle();
        @(negedge clock); chk("lat_edge1", m9.tvalid, 1'b0);
        @(negedge clock); chk("lat_edge2", m9.tvalid, 1'b0);
        @(negedge clock); chk("lat_edge3", m9.tvalid, 1'b1);
        chk("m_tuser", m9.tuser, 1'b0);
        check_stream(0, "good");
        chk("good_ok", ok9, 32'd1);
        chk("good_level", lvl9, 10'd0);

        send(0, 2, 5, 8'hFF, 1'b1, 1'b0);
        idle();
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (m9.tvalid) cnt++;
        end
        chk("err_no_valid", cnt, 0);
        chk("err_cnt", err9, 32'd1);
        chk("err_level", lvl9, 10'd0);
        chk("err_ok", ok9, 32'd1);
        @(posedge clock); #1;
        send(0, 3, 3, 8'h03, 1'b0, 1'b1);
        idle();
        check_stream(0, "after_err");
        chk("after_err_ok", ok9, 32'd2);

        rdy4 = 1'b0;
        send(1, 4, 20, 8'hFF, 1'b0, 1'b0);
        idle();
        repeat (3) @(negedge clock);
        chk("ovs_ovf", ovf4, 32'd1);
        chk("ovs_level", lvl4, 5'd0);
        chk("ovs_ok", ok4, 32'd0);
        @(posedge clock); #1;
        send(1, 5, 10, 8'h3F, 1'b0, 1'b1);
        idle();
        repeat (4) @(negedge clock);
        chk("ovs_next_level", lvl4, 5'd10);
        chk("ovs_next_ok", ok4, 32'd1);
        rdy4 = 1'b1;
        check_stream(1, "after_ovf");
        chk("after_ovf_level", lvl4, 5'd0);

        rdy4 = 1'b0;
        send(1, 6, 16, 8'h01, 1'b0, 1'b1);
        send(1, 7, 4, 8'hFF, 1'b0, 1'b0);
        idle();
        repeat (4) @(negedge clock);
        chk("full_ovf", ovf4, 32'd2);
        chk("full_level", lvl4, 5'd16);
        chk("full_ok", ok4, 32'd2);
        chk("full_err", err4, 32'd0);
        rdy4 = 1'b1;
        check_stream(1, "full");
        chk("full_level_end", lvl4, 5'd0);

        rand_mode = 1'b1;
        send(0, 8, 1, 8'h80, 1'b0, 1'b1);
        send(0, 9, 7, 8'h07, 1'b0, 1'b1);
        send(0, 10, 64, 8'hFF, 1'b0, 1'b1);
        idle();
        check_stream(0, "bp");
        rand_mode = 1'b0;
        chk("bp_ok", ok9, 32'd5);

        rdy9 = 1'b1;
        send(0, 11, 64, 8'h1F, 1'b0, 1'b1);
        idle();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m9.tvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("stream_wait", seen, 1'b1);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (m9.tvalid) cnt++;
            @(negedge clock);
        end
        chk("stream_run", cnt, 64);
        chk("stream_after", m9.tvalid, 1'b0);
        check_stream(0, "stream");
        chk("stream_ok", ok9, 32'd6);

        send(0, 12, 10, 8'hFF, 1'b0, 1'b0);
        idle();
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rx9.size() == 3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("pre_rst_wait", seen, 1'b1);
        chk("pre_rst_beats", rx9.size(), 3);
        chk("pre_rst_valid", m9.tvalid, 1'b1);
        #2 async_resetn = 1'b0;
        #1;
        chk("mid_rst_valid", m9.tvalid, 1'b0);
        chk("mid_rst_ok", ok9, 32'd0);
        chk("mid_rst_err", err9, 32'd0);
        chk("mid_rst_level", lvl9, 10'd0);
        chk("mid_rst_ovf4", ovf4, 32'd0);
        @(negedge clock);
        async_resetn = 1'b1;
        rx9.delete(); exp9.delete();
        @(posedge clock); #1;
        send(0, 13, 4, 8'hF0, 1'b0, 1'b1);
        idle();
        check_stream(0, "post_rst");
        chk("post_rst_ok", ok9, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
